// File: rtl/i_fetch.sv
// Instruction fetch: owns the PC, reads the combinational instruction ROM and
// buffers {pc, inst} pairs in a 2-entry FIFO toward decode (valid/ready).
module i_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address,
    input  logic [31:0] i_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        misalign
);

    logic [31:0] r_pc;
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_inst [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_misalign;

    logic        w_pop;
    logic        w_push;

    assign w_pop  = valid_out & ready_in;
    // A pop frees a slot in the same edge, so a full buffer can still accept a push.
    assign w_push = !redirect & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_misalign <= 1'b0;
        end else if (redirect) begin
            r_pc     <= {redirect_pc[31:2], 2'b00};
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            if (redirect_pc[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Payload storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_pc;
            r_buf_inst[r_wr_ptr] <= i_in;
        end
    end

    assign address   = r_pc;
    assign valid_out = (r_count != 2'd0);
    assign inst_out  = r_buf_inst[r_rd_ptr];
    assign pc_out    = r_buf_pc[r_rd_ptr];
    assign misalign  = r_misalign;

endmodule
